// File: rtl/immed_pkg.sv
// Shared constants and types for the pipelined immediate generator.
package immed_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned IMM_W_DEF  = 16;
    localparam int unsigned OPC_W_DEF  = 6;

    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    typedef enum logic [1:0] {
        SEXT = 2'd0,
        ZEXT = 2'd1,
        HI16 = 2'd2,
        BR   = 2'd3
    } mode_t;

endpackage

// File: rtl/immed_gen_pipe_if.sv
// Producer/consumer handshake bundle of the immediate generator.
interface immed_gen_pipe_if #(
    parameter int unsigned DATA_W = immed_pkg::DATA_W_DEF,
    parameter int unsigned IMM_W  = immed_pkg::IMM_W_DEF,
    parameter int unsigned OPC_W  = immed_pkg::OPC_W_DEF
);
    logic              In_valid;
    logic              In_ready;
    logic [OPC_W-1:0]  Opcode;
    logic [IMM_W-1:0]  Immed_in;
    logic              Out_valid;
    logic              Out_ready;
    logic [DATA_W-1:0] Immed_out;
    logic [DATA_W-1:0] Immed_outPC;
    logic              Illegal;

    // Decode-stage side: supplies instructions, consumes immediates.
    modport master (
        output In_valid, Opcode, Immed_in, Out_ready,
        input  In_ready, Out_valid, Immed_out, Immed_outPC, Illegal
    );

    // Generator side.
    modport slave (
        input  In_valid, Opcode, Immed_in, Out_ready,
        output In_ready, Out_valid, Immed_out, Immed_outPC, Illegal
    );
endinterface

// File: rtl/immed_ext.sv
// Combinational opcode decode and immediate extension.
module immed_ext
    import immed_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMM_W  = IMM_W_DEF,
    parameter int unsigned OPC_W  = OPC_W_DEF
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic [IMM_W-1:0]  immed_in,
    output logic [DATA_W-1:0] immed_out,
    output logic [DATA_W-1:0] immed_out_pc,
    output logic              illegal
);
    // lui lands at bit 16 when it fits, otherwise it is pushed to the top bits.
    localparam int unsigned HI_SH = (DATA_W >= IMM_W + 16) ? 16 : DATA_W - IMM_W;

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    mode_t             mode;

    assign sext         = {{(DATA_W-IMM_W){immed_in[IMM_W-1]}}, immed_in};
    assign zext         = {{(DATA_W-IMM_W){1'b0}}, immed_in};
    assign immed_out_pc = sext << 2;

    // Opcode to extension mode; unknown opcodes fall back to sign extension.
    always_comb begin
        mode    = SEXT;
        illegal = 1'b0;
        case (opcode)
            OPC_W'(OP_ANDI), OPC_W'(OP_ORI):                    mode = ZEXT;
            OPC_W'(OP_LUI):                                     mode = HI16;
            OPC_W'(OP_B), OPC_W'(OP_BEQ), OPC_W'(OP_BNE):       mode = BR;
            OPC_W'(OP_LI), OPC_W'(OP_ADDI), OPC_W'(OP_LB),
            OPC_W'(OP_LW), OPC_W'(OP_SW):                       mode = SEXT;
            default:                                            illegal = 1'b1;
        endcase
    end

    // Select the ALU immediate for the decoded mode.
    always_comb begin
        immed_out = sext;
        case (mode)
            ZEXT:    immed_out = zext;
            HI16:    immed_out = zext << HI_SH;
            default: immed_out = sext;
        endcase
    end

endmodule

// File: rtl/immed_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer.
module immed_gen_pipe
    import immed_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMM_W  = IMM_W_DEF,
    parameter int unsigned OPC_W  = OPC_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Flush,
    immed_gen_pipe_if.slave  bus
);
    localparam int unsigned DEPTH = 2;

    logic [DEPTH-1:0][DATA_W-1:0] imm_q, imm_d;
    logic [DEPTH-1:0][DATA_W-1:0] pc_q, pc_d;
    logic [DEPTH-1:0]             ill_q, ill_d;
    logic [1:0]                   count_q, count_d;
    logic                         valid_q, valid_d;
    logic                         ready_q, ready_d;
    logic                         push, pop, slot;
    logic [DATA_W-1:0]            new_imm, new_pc;
    logic                         new_ill;

    immed_ext #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OPC_W  (OPC_W)
    ) u_ext (
        .opcode       (bus.Opcode),
        .immed_in     (bus.Immed_in),
        .immed_out    (new_imm),
        .immed_out_pc (new_pc),
        .illegal      (new_ill)
    );

    assign push = bus.In_valid & ready_q;
    assign pop  = valid_q & bus.Out_ready;
    // Write slot is the post-pop occupancy; a push never happens while full.
    assign slot = count_q[1] | (count_q[0] & ~pop);

    // Next buffer contents: entry 0 is always the head.
    always_comb begin
        imm_d   = imm_q;
        pc_d    = pc_q;
        ill_d   = ill_q;
        count_d = count_q;
        if (Flush) begin
            count_d = 2'd0;
        end else begin
            if (pop && count_q == 2'd2) begin
                imm_d[0] = imm_q[1];
                pc_d[0]  = pc_q[1];
                ill_d[0] = ill_q[1];
            end
            if (push) begin
                imm_d[slot] = new_imm;
                pc_d[slot]  = new_pc;
                ill_d[slot] = new_ill;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
        valid_d = (count_d != 2'd0);
        ready_d = (count_d < 2'd2);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            imm_q   <= '0;
            pc_q    <= '0;
            ill_q   <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            ill_q   <= ill_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.In_ready    = ready_q;
    assign bus.Out_valid   = valid_q;
    assign bus.Immed_out   = imm_q[0];
    assign bus.Immed_outPC = pc_q[0];
    assign bus.Illegal     = ill_q[0];

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Self-checking bench for immed_gen_pipe: queue model plus directed literals.
module tb_immed_gen_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    immed_gen_pipe_if #(.DATA_W(32), .IMM_W(16), .OPC_W(6)) bus ();

    immed_gen_pipe #(.DATA_W(32), .IMM_W(16), .OPC_W(6)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .Flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t m_q[$];
    logic m_ready = 1'b0;

    // Expected result for one instruction, from the opcode table.
    function automatic exp_t model(input logic [5:0] op, input logic [15:0] imm);
        exp_t        e;
        logic [31:0] sx;
        sx    = 32'($signed(imm));
        e.pc  = sx * 32'd4;
        e.ill = 1'b0;
        case (op)
            6'b110010, 6'b110011: e.imm = 32'(imm);
            6'b111001:            e.imm = 32'(imm) * 32'h0001_0000;
            6'b111111, 6'b000000, 6'b000001,
            6'b111000, 6'b110000, 6'b000011,
            6'b001111, 6'b011111: e.imm = sx;
            default: begin
                e.imm = sx;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of expected entries plus its own ready flag.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ready = 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_ready = 1'b1;
        end else begin
            logic do_pop, do_push;
            do_pop  = (m_q.size() > 0) && bus.Out_ready;
            do_push = bus.In_valid && m_ready;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(model(bus.Opcode, bus.Immed_in));
            m_ready = (m_q.size() < 2);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(bus.In_ready), 32'(m_ready));
        chk("out_valid", 32'(bus.Out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("immed_out", bus.Immed_out, m_q[0].imm);
            chk("immed_outpc", bus.Immed_outPC, m_q[0].pc);
            chk("illegal", 32'(bus.Illegal), 32'(m_q[0].ill));
        end
    end

    // Hold an input until accepted; returns on the negedge after acceptance.
    task automatic send(input logic [5:0] op, input logic [15:0] imm);
        logic got;
        bus.In_valid = 1'b1;
        bus.Opcode   = op;
        bus.Immed_in = imm;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            got = bus.In_ready;
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        bus.In_valid = 1'b0;
    endtask

    logic [5:0]  s_op  [8] = '{6'b110000, 6'b110010, 6'b111001, 6'b000000,
                               6'b101010, 6'b001111, 6'b110011, 6'b111111};
    logic [15:0] s_imm [8] = '{16'h8001, 16'hFFFF, 16'h00A5, 16'h7FFF,
                               16'h0003, 16'h8000, 16'hF00F, 16'h0010};

    initial begin
        bus.In_valid  = 1'b0;
        bus.Opcode    = '0;
        bus.Immed_in  = '0;
        bus.Out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.In_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.Out_valid), 32'd0);
        chk("rst_immed_out", bus.Immed_out, 32'd0);
        chk("rst_immed_outpc", bus.Immed_outPC, 32'd0);
        chk("rst_illegal", 32'(bus.Illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.In_ready), 32'd1);

        // Extension modes, one at a time with the consumer always ready.
        bus.Out_ready = 1'b1;
        send(6'b110000, 16'hFFF0);
        chk("addi_valid", 32'(bus.Out_valid), 32'd1);
        chk("addi_imm", bus.Immed_out, 32'hFFFF_FFF0);
        send(6'b110010, 16'h8001);
        chk("andi_imm", bus.Immed_out, 32'h0000_8001);
        send(6'b111001, 16'h1234);
        chk("lui_imm", bus.Immed_out, 32'h1234_0000);
        send(6'b000000, 16'h001D);
        chk("beq_pc", bus.Immed_outPC, 32'h0000_0074);
        send(6'b000001, 16'hFFFF);
        chk("bne_pc", bus.Immed_outPC, 32'hFFFF_FFFC);
        send(6'b101010, 16'h8000);
        chk("illegal_flag", 32'(bus.Illegal), 32'd1);
        chk("illegal_imm", bus.Immed_out, 32'hFFFF_8000);
        @(negedge clk);

        // Back-pressure: three back-to-back inputs, consumer stalled.
        bus.Out_ready = 1'b0;
        bus.In_valid = 1'b1; bus.Opcode = 6'b110000; bus.Immed_in = 16'h0001;
        @(negedge clk);
        bus.Opcode = 6'b001111; bus.Immed_in = 16'h7FFF;
        @(negedge clk);
        bus.Opcode = 6'b011111; bus.Immed_in = 16'h8000;
        chk("full_ready", 32'(bus.In_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(bus.In_ready), 32'd0);
            chk("stall_head", bus.Immed_out, 32'h0000_0001);
        end
        bus.Out_ready = 1'b1;
        @(negedge clk);
        chk("drain_b", bus.Immed_out, 32'h0000_7FFF);
        chk("drain_ready", 32'(bus.In_ready), 32'd1);
        @(negedge clk);
        bus.In_valid = 1'b0;
        chk("drain_c", bus.Immed_out, 32'hFFFF_8000);
        @(negedge clk);
        chk("drain_empty", 32'(bus.Out_valid), 32'd0);

        // Flush while full, with a simultaneous input.
        bus.Out_ready = 1'b0;
        bus.In_valid = 1'b1; bus.Opcode = 6'b110000; bus.Immed_in = 16'h0002;
        @(negedge clk);
        bus.Immed_in = 16'h0003;
        @(negedge clk);
        flush = 1'b1; bus.Opcode = 6'b110011; bus.Immed_in = 16'h5555;
        @(negedge clk);
        flush = 1'b0; bus.In_valid = 1'b0;
        chk("flush_valid", 32'(bus.Out_valid), 32'd0);
        chk("flush_ready", 32'(bus.In_ready), 32'd1);
        @(negedge clk);
        chk("flush_dropped", 32'(bus.Out_valid), 32'd0);

        // Flush with one entry while the input is accepted-eligible.
        bus.In_valid = 1'b1; bus.Opcode = 6'b111000; bus.Immed_in = 16'h0004;
        @(negedge clk);
        flush = 1'b1; bus.Immed_in = 16'h0005;
        @(negedge clk);
        flush = 1'b0; bus.In_valid = 1'b0;
        chk("flush1_valid", 32'(bus.Out_valid), 32'd0);
        @(negedge clk);
        chk("flush1_dropped", 32'(bus.Out_valid), 32'd0);

        // Asynchronous reset with the buffer full.
        bus.In_valid = 1'b1; bus.Opcode = 6'b110000; bus.Immed_in = 16'h0006;
        @(negedge clk);
        bus.Immed_in = 16'h0007;
        @(negedge clk);
        bus.In_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.Out_valid), 32'd0);
        chk("arst_ready", 32'(bus.In_ready), 32'd0);
        chk("arst_imm", bus.Immed_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_release_ready", 32'(bus.In_ready), 32'd1);
        chk("arst_release_valid", 32'(bus.Out_valid), 32'd0);

        // Mixed stream with intermittent consumer stalls.
        begin
            int   idx;
            logic got;
            logic [39:0] rdy_pat;
            idx = 0;
            rdy_pat = 40'b1011_0011_1110_0101_1101_1000_1111_0110_0111_1011;
            for (int i = 0; i < 40; i++) begin
                bus.In_valid  = (idx < 16);
                bus.Opcode    = s_op[idx % 8];
                bus.Immed_in  = s_imm[idx % 8] ^ 16'(idx);
                bus.Out_ready = rdy_pat[i];
                got = bus.In_ready && bus.In_valid;
                @(negedge clk);
                if (got) idx++;
            end
            bus.In_valid  = 1'b0;
            bus.Out_ready = 1'b1;
            repeat (4) @(negedge clk);
            chk("stream_drained", 32'(bus.Out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
